// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining MMIO TO_HOST writes into UARTTX one frame at a time
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wdata,
  input  logic          we,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_data,
  output logic          tx_we,
  input  logic          tx_ready
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            ovf_set;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Strobes: flush swallows both a same-cycle push (silently) and a same-cycle pop
  always_comb begin
    push    = we && !full && !flush;
    ovf_set = we && full && !flush;
    pop     = (state == IDLE) && !empty && tx_ready && !flush;
  end

  // Next-state: one frame handed to UARTTX per IDLE->SEND->GAP->WAIT round
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = SEND;
      SEND:    next_state = GAP;
      GAP:     next_state = WAIT;   // READY is stale here, UARTTX drops it one cycle after WE
      WAIT:    if (tx_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy counter; flush discards queued bytes but not the in-flight one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + (AW+1)'(1);
        end else if (pop && !push) begin
          count <= count - (AW+1)'(1);
        end
      end
    end
  end

  // Sticky overflow: a dropped push beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Registered UARTTX outputs: data latched at pop and held until the next pop, WE high only in SEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= 8'h00;
      tx_we   <= 1'b0;
    end else begin
      tx_we <= (next_state == SEND);
      if (pop) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wdata;
  logic        we;
  logic        flush;
  logic        clr_ovf;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_ready;

  logic        model_en;
  logic        man_ready;
  int          busy;

  int          vectors = 0;
  int          errors  = 0;

  logic [7:0]  rx [$];
  logic [7:0]  exp6 [20];
  logic        prev_we = 1'b0;
  logic        hold_pending = 1'b0;
  logic [7:0]  held = 8'h00;
  int          base;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wdata    (wdata),
    .we       (we),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_we    (tx_we),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // UARTTX stand-in: READY low for 10 cycles after each WE
  always @(posedge clk or posedge rst) begin
    if (rst) busy <= 0;
    else if (tx_we) busy <= 10;
    else if (busy != 0) busy <= busy - 1;
  end

  assign tx_ready = model_en ? (busy == 0) : man_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame monitor: records each byte, checks single-cycle WE and data held after it
  always @(negedge clk) begin
    if (tx_we) begin
      rx.push_back(tx_data);
      chk("tx_we_pulse_width", {31'd0, prev_we}, 32'd0);
      held = tx_data;
      hold_pending = 1'b1;
    end else if (hold_pending) begin
      chk("tx_data_hold", {24'd0, tx_data}, {24'd0, held});
      hold_pending = 1'b0;
    end
    prev_we = tx_we;
  end

  initial begin
    rst = 1'b1; wdata = 8'h00; we = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    model_en = 1'b0; man_ready = 1'b1;

    // 1: reset state, single byte latency
    tick(); tick();
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_we", {31'd0, tx_we}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    rst = 1'b0;
    tick();
    base = rx.size();
    we = 1'b1; wdata = 8'h41;
    tick();
    we = 1'b0;
    chk("t1_count_n1", {27'd0, count}, 32'd1);
    chk("t1_tx_we_n1", {31'd0, tx_we}, 32'd0);
    tick();
    chk("t1_tx_we_n2", {31'd0, tx_we}, 32'd1);
    chk("t1_tx_data_n2", {24'd0, tx_data}, 32'h41);
    chk("t1_count_n2", {27'd0, count}, 32'd0);
    tick();
    chk("t1_tx_we_gap", {31'd0, tx_we}, 32'd0);
    tick(); tick();
    chk("t1_rx_count", rx.size(), base + 1);

    // 2: overfill with READY low, then drain in order
    man_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      we = 1'b1; wdata = 8'(i);
      tick();
      if (i == 14) chk("t2_full_at_15", {31'd0, full}, 32'd0);
      if (i == 15) chk("t2_full_at_16", {31'd0, full}, 32'd1);
    end
    we = 1'b0;
    chk("t2_count", {27'd0, count}, 32'd16);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    base = rx.size();
    model_en = 1'b1;
    for (int k = 0; k < 1000 && rx.size() < base + 16; k++) tick();
    chk("t2_rx_count", rx.size(), base + 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < rx.size()) chk($sformatf("t2_rx_%0d", i), {24'd0, rx[base+i]}, i);
    end
    repeat (15) tick();
    chk("t2_empty", {31'd0, empty}, 32'd1);
    chk("t2_rx_no_extra", rx.size(), base + 16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_clr_ovf", {31'd0, overflow}, 32'd0);

    // 3: full FIFO, drop races with clr_ovf, then push in the pop cycle
    model_en = 1'b0; man_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wdata = 8'hA0 + 8'(i);
      tick();
    end
    chk("t3_full", {31'd0, full}, 32'd1);
    wdata = 8'hDD; clr_ovf = 1'b1;
    tick();
    we = 1'b0; clr_ovf = 1'b0;
    chk("t3_set_wins", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_cleared", {31'd0, overflow}, 32'd0);
    base = rx.size();
    man_ready = 1'b1; we = 1'b1; wdata = 8'hEE;
    tick();
    we = 1'b0; man_ready = 1'b0;
    chk("t3_count", {27'd0, count}, 32'd15);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_full_after", {31'd0, full}, 32'd0);
    chk("t3_tx_we", {31'd0, tx_we}, 32'd1);
    chk("t3_tx_data", {24'd0, tx_data}, 32'hA0);
    tick(); tick();
    chk("t3_count_wait", {27'd0, count}, 32'd15);

    // 4: flush while a byte is in WAIT, with a same-cycle push
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    flush = 1'b1; we = 1'b1; wdata = 8'h77;
    tick();
    flush = 1'b0; we = 1'b0;
    chk("t4_count", {27'd0, count}, 32'd0);
    chk("t4_empty", {31'd0, empty}, 32'd1);
    chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
    man_ready = 1'b1;
    repeat (12) tick();
    chk("t4_rx_only_inflight", rx.size(), base + 1);
    chk("t4_count_after", {27'd0, count}, 32'd0);
    man_ready = 1'b0;
    we = 1'b1; wdata = 8'h55;
    tick();
    wdata = 8'h66;
    tick();
    we = 1'b0;
    chk("t4b_count2", {27'd0, count}, 32'd2);
    flush = 1'b1; man_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4b_flush_count", {27'd0, count}, 32'd0);
    chk("t4b_no_pop_we", {31'd0, tx_we}, 32'd0);
    tick();
    chk("t4b_no_pop_we2", {31'd0, tx_we}, 32'd0);

    // 5: async reset during SEND
    we = 1'b1; wdata = 8'hC1;
    tick();
    wdata = 8'hC2;
    tick();
    we = 1'b0;
    chk("t5_tx_we", {31'd0, tx_we}, 32'd1);
    chk("t5_tx_data", {24'd0, tx_data}, 32'hC1);
    chk("t5_count", {27'd0, count}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tx_we", {31'd0, tx_we}, 32'd0);
    chk("t5_rst_count", {27'd0, count}, 32'd0);
    chk("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 6: 20 bytes against the UARTTX stand-in
    model_en = 1'b1;
    base = rx.size();
    for (int i = 0; i < 20; i++) exp6[i] = 8'(i * 37 + 19);
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; wdata = exp6[i];
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 500 && rx.size() < base + 10; k++) tick();
    for (int i = 10; i < 20; i++) begin
      we = 1'b1; wdata = exp6[i];
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 500 && rx.size() < base + 20; k++) tick();
    repeat (30) tick();
    chk("t6_rx_count", rx.size(), base + 20);
    for (int i = 0; i < 20; i++) begin
      if (base + i < rx.size()) chk($sformatf("t6_rx_%0d", i), {24'd0, rx[base+i]}, {24'd0, exp6[i]});
    end
    chk("t6_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
